// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// hex font (bit0 = a ... bit6 = g, active-high) and width helpers.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_DASH  = 7'h40;

  localparam seg_t SEG_HEX_0 = 7'h3F;
  localparam seg_t SEG_HEX_1 = 7'h06;
  localparam seg_t SEG_HEX_2 = 7'h5B;
  localparam seg_t SEG_HEX_3 = 7'h4F;
  localparam seg_t SEG_HEX_4 = 7'h66;
  localparam seg_t SEG_HEX_5 = 7'h6D;
  localparam seg_t SEG_HEX_6 = 7'h7D;
  localparam seg_t SEG_HEX_7 = 7'h07;
  localparam seg_t SEG_HEX_8 = 7'h7F;
  localparam seg_t SEG_HEX_9 = 7'h6F;
  localparam seg_t SEG_HEX_A = 7'h77;
  localparam seg_t SEG_HEX_B = 7'h7C;
  localparam seg_t SEG_HEX_C = 7'h39;
  localparam seg_t SEG_HEX_D = 7'h5E;
  localparam seg_t SEG_HEX_E = 7'h79;
  localparam seg_t SEG_HEX_F = 7'h71;

  // Number of bits needed to count 0..n-1 (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Counter / select width that never collapses to zero bits.
  function automatic int width_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Bundle of channel data, display controls and pin-level outputs of the
// scan driver. The board/bench side uses master, the driver uses slave.
interface seg7_scan_display_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_CH     = 4
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int CSW    = width_of(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [CSW-1:0]           ch_sel;
  logic                     auto_mode;
  logic                     freeze;
  logic                     blank_zeros;
  logic [6:0]               seg;
  logic [NUM_DIGITS-1:0]    an;
  logic [CSW-1:0]           cur_ch;
  logic                     frame_done;

  modport master (
    output ch_data, ch_sel, auto_mode, freeze, blank_zeros,
    input  seg, an, cur_ch, frame_done
  );

  modport slave (
    input  ch_data, ch_sel, auto_mode, freeze, blank_zeros,
    output seg, an, cur_ch, frame_done
  );

endinterface

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Font lookup for one nibble.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed seven-segment driver. One digit is refreshed per scan
// slot; each frame shows a snapshot of one channel taken at frame start.
// A single shared font decoder serves all digits.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int NUM_CH       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DWELL_FRAMES = 256,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  seg7_scan_display_if.slave bus
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int CSW    = width_of(NUM_CH);
  localparam int DIW    = width_of(NUM_DIGITS);
  localparam int PSW    = width_of(SCAN_DIV);
  localparam int DWW    = width_of(DWELL_FRAMES);

  logic [PSW-1:0]        presc;
  logic                  tick;
  logic [DIW-1:0]        digit_idx;
  logic                  last_digit;
  logic                  frame_start;
  logic                  capture;

  logic [CSW-1:0]        cur_ch;
  logic [CSW-1:0]        next_ch;
  logic [CSW-1:0]        disp_ch;
  logic [DWW-1:0]        dwell_cnt;
  logic                  dwell_wrap;

  logic [DATA_W-1:0]     snapshot;
  logic [DATA_W-1:0]     next_data;
  logic [DATA_W-1:0]     disp_data;
  logic [NUM_DIGITS-1:0] zero_from;

  logic [3:0]            nibble;
  logic                  blank;
  logic                  disp_dash;
  seg_t                  font_seg;
  seg_t                  seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  seg_t                  seg_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  frame_done_r;

  assign tick        = (int'(presc) == SCAN_DIV - 1);
  assign last_digit  = (int'(digit_idx) == NUM_DIGITS - 1);
  assign frame_start = tick && (digit_idx == '0);
  assign capture     = frame_start && !bus.freeze;
  assign dwell_wrap  = (int'(dwell_cnt) == DWELL_FRAMES - 1);

  // Scan-slot prescaler; tick marks the last clock of each slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PSW'(1);
    end
  end

  // Channel chosen for the coming frame: manual select or auto rotation.
  always_comb begin
    next_ch = cur_ch;
    if (bus.auto_mode) begin
      if (dwell_wrap) begin
        next_ch = (int'(cur_ch) >= NUM_CH - 1) ? '0 : cur_ch + CSW'(1);
      end
    end else begin
      next_ch = bus.ch_sel;
    end
  end

  // Channel data for next_ch; an out-of-range channel reads as zero.
  always_comb begin
    next_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (next_ch == CSW'(k)) begin
        next_data = bus.ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // The digit loaded at frame start bypasses the snapshot register so the
  // whole frame comes from the value captured on that same edge.
  always_comb begin
    disp_ch   = capture ? next_ch : cur_ch;
    disp_data = capture ? next_data : snapshot;
    disp_dash = (int'(disp_ch) >= NUM_CH);
  end

  // zero_from[i]: nibbles i..top of the displayed value are all zero.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc          = acc && (disp_data[4*i +: 4] == 4'h0);
      zero_from[i] = acc;
    end
  end

  // Select the active digit's nibble, enable and blanking decision.
  always_comb begin
    nibble  = 4'h0;
    an_next = '0;
    blank   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == DIW'(i)) begin
        nibble     = disp_data[4*i +: 4];
        an_next[i] = 1'b1;
        blank      = bus.blank_zeros && (i != 0) && zero_from[i];
      end
    end
  end

  hex_to_seg7 u_font (
    .nibble (nibble),
    .seg    (font_seg)
  );

  // Final segment pattern: dash overrides blanking, blanking overrides font.
  always_comb begin
    seg_next = font_seg;
    if (disp_dash) begin
      seg_next = SEG_DASH;
    end else if (blank) begin
      seg_next = SEG_BLANK;
    end
  end

  // Digit scan: load the current digit's pattern and step to the next one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_idx    <= '0;
      seg_r        <= SEG_BLANK;
      an_r         <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= tick && last_digit;
      if (tick) begin
        seg_r     <= seg_next;
        an_r      <= an_next;
        digit_idx <= last_digit ? '0 : digit_idx + DIW'(1);
      end
    end
  end

  // Per-frame channel and snapshot capture; dwell only runs in auto mode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_ch    <= '0;
      snapshot  <= '0;
      dwell_cnt <= '0;
    end else begin
      if (capture) begin
        cur_ch   <= next_ch;
        snapshot <= next_data;
      end
      if (!bus.auto_mode) begin
        dwell_cnt <= '0;
      end else if (capture) begin
        dwell_cnt <= dwell_wrap ? '0 : dwell_cnt + DWW'(1);
      end
    end
  end

  assign bus.seg        = ACTIVE_LOW ? ~seg_r : seg_r;
  assign bus.an         = ACTIVE_LOW ? ~an_r : an_r;
  assign bus.cur_ch     = cur_ch;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for the seven-segment scan driver: a vector table for the
// frame contents plus hand-written sequences for the multi-frame cases.
module tb_seg7_scan_display;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  seg7_scan_display_if #(.NUM_DIGITS(4), .NUM_CH(4)) bus_m ();
  seg7_scan_display_if #(.NUM_DIGITS(4), .NUM_CH(3)) bus_o ();

  seg7_scan_display #(
    .NUM_DIGITS(4), .NUM_CH(4), .SCAN_DIV(4), .DWELL_FRAMES(2), .ACTIVE_LOW(1'b0)
  ) u_main (
    .clock (clock),
    .reset (reset),
    .bus   (bus_m)
  );

  seg7_scan_display #(
    .NUM_DIGITS(4), .NUM_CH(3), .SCAN_DIV(4), .DWELL_FRAMES(2), .ACTIVE_LOW(1'b0)
  ) u_odd (
    .clock (clock),
    .reset (reset),
    .bus   (bus_o)
  );

  typedef struct {
    logic [15:0]     data;
    logic            blank;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t vecs[6];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ec     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ec);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ec++;
  endtask

  task automatic goto_edge(input int e);
    if (ec > e) begin
      n_chk++;
      n_fail++;
      $display("FAIL sequencing: at edge %0d, required edge %0d", ec, e);
    end
    while (ec < e) step();
  endtask

  function automatic int next_frame();
    return (ec < 4) ? 0 : (ec - 4) / 16 + 1;
  endfunction

  function automatic int slot(input int f, input int d);
    return 16 * f + 4 + 4 * d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    logic [6:0] d0font [4];
    int seq [9];
    logic [6:0] old_segs [4];

    vecs[0] = '{16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{16'h0040, 1'b1, {7'h00, 7'h00, 7'h66, 7'h3F}};
    vecs[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[3] = '{16'h0040, 1'b0, {7'h3F, 7'h3F, 7'h66, 7'h3F}};
    vecs[4] = '{16'hF00E, 1'b1, {7'h71, 7'h3F, 7'h3F, 7'h79}};
    vecs[5] = '{16'h00A0, 1'b1, {7'h00, 7'h00, 7'h77, 7'h3F}};
    d0font = '{7'h66, 7'h5E, 7'h7F, 7'h79};
    seq    = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    old_segs = '{7'h66, 7'h4F, 7'h5B, 7'h06};

    bus_m.ch_data     = {16'h9ABE, 16'h5678, 16'hABCD, 16'h1234};
    bus_m.ch_sel      = 2'd0;
    bus_m.auto_mode   = 1'b0;
    bus_m.freeze      = 1'b0;
    bus_m.blank_zeros = 1'b0;
    bus_o.ch_data     = {16'h00C0, 16'h5555, 16'h7777};
    bus_o.ch_sel      = 2'd3;
    bus_o.auto_mode   = 1'b0;
    bus_o.freeze      = 1'b0;
    bus_o.blank_zeros = 1'b0;

    // Reset state
    reset = 1'b1;
    #1;
    chk("reset_seg", 32'(bus_m.seg), 32'h0);
    chk("reset_an", 32'(bus_m.an), 32'h0);
    chk("reset_cur_ch", 32'(bus_m.cur_ch), 32'h0);
    chk("reset_frame_done", 32'(bus_m.frame_done), 32'h0);
    #1;
    reset = 1'b0;
    ec = 0;

    // First tick lands SCAN_DIV clocks after release; an holds for a slot
    goto_edge(3);
    chk("first_tick_early_an", 32'(bus_m.an), 32'h0);
    goto_edge(4);
    chk("first_tick_an", 32'(bus_m.an), 32'h1);
    chk("first_tick_seg", 32'(bus_m.seg), 32'h66);
    goto_edge(7);
    chk("slot_hold_an", 32'(bus_m.an), 32'h1);
    goto_edge(8);
    chk("second_slot_an", 32'(bus_m.an), 32'h2);

    // Frame contents and blanking, one table row per frame
    for (int v = 0; v < 6; v++) begin
      bus_m.ch_data[15:0] = vecs[v].data;
      bus_m.blank_zeros   = vecs[v].blank;
      f = next_frame();
      for (int d = 0; d < 4; d++) begin
        goto_edge(slot(f, d));
        chk($sformatf("vec%0d_an_d%0d", v, d), 32'(bus_m.an), 32'(1) << d);
        chk($sformatf("vec%0d_seg_d%0d", v, d), 32'(bus_m.seg), 32'(vecs[v].segs[d]));
        chk($sformatf("vec%0d_frame_done_d%0d", v, d), 32'(bus_m.frame_done),
            (d == 3) ? 32'h1 : 32'h0);
      end
      step();
      chk($sformatf("vec%0d_frame_done_end", v), 32'(bus_m.frame_done), 32'h0);
    end

    // Mid-frame channel switch takes effect only at the next frame
    bus_m.ch_data[15:0] = 16'h1234;
    bus_m.blank_zeros   = 1'b0;
    f = next_frame();
    goto_edge(slot(f, 0));
    chk("switch_cur_ch_before", 32'(bus_m.cur_ch), 32'h0);
    goto_edge(slot(f, 2));
    bus_m.ch_sel = 2'd1;
    goto_edge(slot(f, 3));
    chk("switch_same_frame_seg", 32'(bus_m.seg), 32'h06);
    chk("switch_same_frame_ch", 32'(bus_m.cur_ch), 32'h0);
    goto_edge(slot(f + 1, 0));
    chk("switch_next_cur_ch", 32'(bus_m.cur_ch), 32'h1);
    chk("switch_next_seg_d0", 32'(bus_m.seg), 32'h5E);
    goto_edge(slot(f + 1, 1));
    chk("switch_next_seg_d1", 32'(bus_m.seg), 32'h39);

    // Auto rotation with a two-frame dwell; ch_sel ignored
    bus_m.ch_sel = 2'd0;
    f = next_frame();
    goto_edge(slot(f, 0));
    chk("auto_start_ch", 32'(bus_m.cur_ch), 32'h0);
    goto_edge(slot(f, 1));
    bus_m.auto_mode = 1'b1;
    bus_m.ch_sel    = 2'd2;
    chk("auto_seq0", 32'(bus_m.cur_ch), 32'(seq[0]));
    for (int j = 1; j < 9; j++) begin
      goto_edge(slot(f + j, 0));
      chk($sformatf("auto_seq%0d", j), 32'(bus_m.cur_ch), 32'(seq[j]));
      chk($sformatf("auto_seg%0d", j), 32'(bus_m.seg), 32'(d0font[seq[j]]));
    end
    goto_edge(slot(f + 8, 1));
    bus_m.auto_mode = 1'b0;
    bus_m.ch_sel    = 2'd0;

    // Freeze holds snapshot and channel while the scan keeps running
    f = next_frame();
    goto_edge(slot(f, 0));
    chk("freeze_pre_seg", 32'(bus_m.seg), 32'h66);
    goto_edge(slot(f, 1));
    bus_m.freeze        = 1'b1;
    bus_m.ch_data[15:0] = 16'hFFFF;
    bus_m.ch_sel        = 2'd1;
    for (int d = 0; d < 4; d++) begin
      goto_edge(slot(f + 1, d));
      chk($sformatf("freeze_an_d%0d", d), 32'(bus_m.an), 32'(1) << d);
      chk($sformatf("freeze_seg_d%0d", d), 32'(bus_m.seg), 32'(old_segs[d]));
    end
    chk("freeze_cur_ch", 32'(bus_m.cur_ch), 32'h0);
    goto_edge(slot(f + 2, 1));
    chk("freeze_hold_seg", 32'(bus_m.seg), 32'h4F);
    bus_m.ch_sel = 2'd0;
    bus_m.freeze = 1'b0;
    for (int d = 0; d < 4; d++) begin
      goto_edge(slot(f + 3, d));
      chk($sformatf("unfreeze_seg_d%0d", d), 32'(bus_m.seg), 32'h71);
    end

    // Out-of-range channel on the three-channel instance shows dashes
    f = next_frame();
    for (int d = 0; d < 4; d++) begin
      goto_edge(slot(f, d));
      chk($sformatf("oor_seg_d%0d", d), 32'(bus_o.seg), 32'h40);
      chk($sformatf("oor_an_d%0d", d), 32'(bus_o.an), 32'(1) << d);
    end
    chk("oor_cur_ch", 32'(bus_o.cur_ch), 32'h3);
    bus_o.ch_sel = 2'd2;
    goto_edge(slot(f + 1, 0));
    chk("odd_ch2_cur_ch", 32'(bus_o.cur_ch), 32'h2);
    chk("odd_ch2_seg_d0", 32'(bus_o.seg), 32'h3F);
    goto_edge(slot(f + 1, 1));
    chk("odd_ch2_seg_d1", 32'(bus_o.seg), 32'h39);

    // Asynchronous reset in the middle of a frame
    bus_m.ch_sel = 2'd1;
    f = next_frame();
    goto_edge(slot(f, 2));
    chk("pre_areset_an", 32'(bus_m.an), 32'h4);
    #3;
    reset = 1'b1;
    #1;
    chk("areset_seg", 32'(bus_m.seg), 32'h0);
    chk("areset_an", 32'(bus_m.an), 32'h0);
    chk("areset_cur_ch", 32'(bus_m.cur_ch), 32'h0);
    chk("areset_odd_an", 32'(bus_o.an), 32'h0);
    #2;
    reset = 1'b0;
    ec = 0;
    goto_edge(3);
    chk("restart_early_an", 32'(bus_m.an), 32'h0);
    goto_edge(4);
    chk("restart_an_d0", 32'(bus_m.an), 32'h1);
    chk("restart_seg_d0", 32'(bus_m.seg), 32'h5E);
    chk("restart_cur_ch", 32'(bus_m.cur_ch), 32'h1);
    goto_edge(8);
    chk("restart_an_d1", 32'(bus_m.an), 32'h2);
    goto_edge(16);
    chk("restart_frame_done", 32'(bus_m.frame_done), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Parametrised, time-multiplexed seven-segment display driver for the CPU board top level. It shows one of NUM_CH packed register channels (AC, IR, DR, ...) on NUM_DIGITS hex digits by scanning one digit at a time. Channels are selected manually or auto-rotated. Each frame uses a coherent snapshot of the data, with optional freeze and leading-zero blanking. It replaces the static per-digit decode path with a single shared decoder and scan counters.

Parameters:
NUM_DIGITS, 4, digits scanned; DATA_W = 4*NUM_DIGITS (derived, not overridable)
NUM_CH, 4, number of selectable channels (>=1)
SCAN_DIV, 50000, clocks per digit slot (>=2)
DWELL_FRAMES, 256, frames per channel in auto mode (>=1)
ACTIVE_LOW, 1, 1 = seg and an outputs inverted at the pins

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ch_data  in  NUM_CH*DATA_W  packed channels; channel k = bits [k*DATA_W +: DATA_W]
ch_sel  in  CSW  manual channel select; CSW = max(1, clog2(NUM_CH))
auto_mode  in  1  1 = auto-rotate channels
freeze  in  1  1 = hold snapshot and channel
blank_zeros  in  1  1 = leading-zero suppression
seg  out  7  segments; bit0 = a … bit6 = g
an  out  NUM_DIGITS  digit enables; bit i = digit i (digit 0 = least significant nibble)
cur_ch  out  CSW  channel currently displayed
frame_done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset: async, active-high. Clears prescaler, digit_idx, dwell_cnt, cur_ch and the snapshot to 0. frame_done = 0. seg and an go to the inactive level (all 1 if ACTIVE_LOW, else all 0) immediately, with no clock edge needed.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick = (count == SCAN_DIV-1). The first tick occurs SCAN_DIV clocks after reset release.
- Scan: on each tick, the seg/an registers load the pattern of digit digit_idx. digit_idx then advances and wraps from NUM_DIGITS-1 to 0. Exactly one an bit is active after the first tick. Outputs are registered and change on the clock edge at which tick = 1.
- Frame start (tick with digit_idx == 0), when freeze = 0:
  - Manual mode: next_ch = ch_sel.
  - Auto mode: if dwell_cnt == DWELL_FRAMES-1, then next_ch = cur_ch+1 (wrapping NUM_CH-1 to 0) and dwell_cnt clears. Otherwise next_ch = cur_ch and dwell_cnt increments.
  - On this edge: cur_ch <= next_ch and snapshot <= channel next_ch. The digit-0 pattern loaded on this edge comes from the value being captured (bypass).
- Frame start, when freeze = 1: snapshot, cur_ch and dwell_cnt hold. Scanning continues.
- Mid-frame changes to ch_sel, ch_data or auto_mode have no visible effect until the next frame start.
- Entering auto mode keeps the current cur_ch. dwell_cnt is held at 0 while in manual mode.
- Out of range: if next_ch >= NUM_CH (only possible when NUM_CH is not a power of 2), cur_ch still takes the value, but every digit shows a dash (segment g only).
- frame_done = 1 for the one cycle after the tick that loads digit NUM_DIGITS-1.
- Blanking: when blank_zeros = 1, digit i (i>0) is blanked (all segments off, an still active) if snapshot nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
- Polarity: internal logic is active-high. ACTIVE_LOW inverts seg and an only at the output.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'h00
  - SEG_DASH = 7'h40
  - hex font constants 0-F, in the a..g order above
  - clog2 function used to derive CSW
- Sub-module hex_to_seg7: purely combinational, 4-bit nibble to 7-bit active-high pattern. Instanced once and fed by the digit mux.

Test Plan:
Common bench parameters: SCAN_DIV=4, NUM_DIGITS=4, NUM_CH=4, ACTIVE_LOW=0.
1. Reset, then manual mode with ch_sel=0 and ch0=16'h1234.
   -> an steps 0001→0010→0100→1000, one step every 4 clocks.
   -> seg shows the font for 4, 3, 2, 1 in that order.
   -> frame_done pulses every 16 clocks.
2. blank_zeros=1.
   -> ch0=16'h0040: digits 3 and 2 show 7'h00, digit 1 shows '4', digit 0 shows '0'.
   -> ch0=16'h0000: only digit 0 lit ('0').
3. Switch ch_sel 0→1 during digit 2 of a frame, with ch1=16'hABCD.
   -> The rest of that frame still shows ch0 data.
   -> At the next frame start, cur_ch=1 and digit 0 shows 'D'.
4. auto_mode=1 with DWELL_FRAMES=2.
   -> cur_ch per frame: 0,0,1,1,2,2,3,3,0.
   -> Changes to ch_sel are ignored.
5. freeze=1, then ch0 changes to 16'hFFFF.
   -> Display keeps the old value, cur_ch holds, an keeps scanning.
   -> After freeze=0, the next frame shows FFFF.
6. Two cases:
   -> NUM_CH=3, ch_sel=3: cur_ch=3 and all digits show SEG_DASH.
   -> Async reset asserted mid-frame: seg and an go inactive within the same cycle, and digit_idx restarts at 0.
